maze_room_map: RTL and testbench

Parametrised room-map engine for the maze game: holds a MAP_W × MAP_H grid of rooms, each encoded as a 4-bit open-sides mask. It runs in the CLOCK_25 pixel domain between the VGA timing counters and the player logic. Per pixel it produces a registered wall flag. Per move request it answers collision and detects room-exit. On an exit through an open side into an existing neighbour it runs a frame-counted fade-out / swap / fade-in transition.

---
 rtl/maze_room_map_pkg.sv | 15 +
 rtl/maze_room_map_if.sv | 7 +
 rtl/maze_room_map_wall_test.sv | 46 ++++
 rtl/maze_room_map.sv | 104 ++++++++++
 tb/tb_maze_room_map.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_room_map_pkg.sv
// maze_pkg: side encodings, mask bit positions, FSM states and legacy tiles
package maze_pkg;
  typedef enum logic [1:0] {SIDE_N = 2'd0, SIDE_E = 2'd1, SIDE_S = 2'd2, SIDE_W = 2'd3} side_t;
  typedef enum logic [1:0] {ST_IDLE, ST_FADE_OUT, ST_SWAP, ST_FADE_IN} state_t;
  localparam int BIT_N = 3;
  localparam int BIT_E = 2;
  localparam int BIT_S = 1;
  localparam int BIT_W = 0;
  localparam logic [3:0] ROOM_VERT  = 4'b1010;
  localparam logic [3:0] ROOM_HORZ  = 4'b0101;
  localparam logic [3:0] ROOM_CROSS = 4'b1111;
  function automatic logic [1:0] side_bit(side_t s);
    return 2'd3 - s;
  endfunction
endpackage

// File: rtl/maze_room_map_if.sv
// maze_room_map_if: player move request and its accept/reject verdict
interface maze_room_map_if;
  logic [9:0] next_x, next_y;
  logic       next_valid, next_ok, next_blocked;
  modport master (output next_x, next_y, next_valid, input next_ok, next_blocked);
  modport slave (input next_x, next_y, next_valid, output next_ok, next_blocked);
endinterface

// File: rtl/maze_room_map_wall_test.sv
// maze_wall_test: does a BOX x BOX square at (x,y) touch a wall of the room, and which active edges does it cross
module maze_wall_test import maze_pkg::*; #(
  parameter int H_OFF = 96,
  parameter int V_OFF = 2,
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int WALL  = 100,
  parameter int BOX   = 16
) (
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic [3:0]  mask,
  output logic        hit,
  output logic [3:0]  out
);
  localparam logic [10:0] XA = 11'(H_OFF);
  localparam logic [10:0] XW = 11'(H_OFF + WALL);
  localparam logic [10:0] XE = 11'(H_OFF + H_ACT - WALL);
  localparam logic [10:0] XB = 11'(H_OFF + H_ACT);
  localparam logic [10:0] YA = 11'(V_OFF);
  localparam logic [10:0] YW = 11'(V_OFF + WALL);
  localparam logic [10:0] YE = 11'(V_OFF + V_ACT - WALL);
  localparam logic [10:0] YB = 11'(V_OFF + V_ACT);
  localparam logic [10:0] B  = 11'(BOX);
  logic [10:0] xe, ye;
  logic bx_w, bx_e, bx_a, by_n, by_s, by_a;
  function automatic logic span(input logic [10:0] s, e, lo, hi);
    return s < hi && e > lo;
  endfunction
  assign xe = x + B;
  assign ye = y + B;
  assign bx_w = span(x, xe, XA, XW);
  assign bx_e = span(x, xe, XE, XB);
  assign bx_a = span(x, xe, XA, XB);
  assign by_n = span(y, ye, YA, YW);
  assign by_s = span(y, ye, YE, YB);
  assign by_a = span(y, ye, YA, YB);
  // corners are wall whatever the mask says; bands only where that side is closed
  assign hit = ((bx_w | bx_e) & (by_n | by_s))
             | (by_n & bx_a & ~mask[BIT_N]) | (by_s & bx_a & ~mask[BIT_S])
             | (bx_w & by_a & ~mask[BIT_W]) | (bx_e & by_a & ~mask[BIT_E]);
  assign out[BIT_N] = y < YA;
  assign out[BIT_E] = xe > XB;
  assign out[BIT_S] = ye > YB;
  assign out[BIT_W] = x < XA;
endmodule

// File: rtl/maze_room_map.sv
// maze_room_map: per-pixel wall flag, move arbitration and fade/swap room transitions
module maze_room_map import maze_pkg::*; #(
  parameter int MAP_W = 3,
  parameter int MAP_H = 3,
  parameter logic [MAP_W*MAP_H*4-1:0] MAP_INIT = {4'h6, 4'h3, 4'hD, 4'h0, ROOM_CROSS, ROOM_VERT, ROOM_CROSS, ROOM_HORZ, ROOM_VERT},
  parameter int START_X = 1,
  parameter int START_Y = 2,
  parameter int H_OFF = 96,
  parameter int V_OFF = 2,
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int WALL = 100,
  parameter int PLAYER = 16,
  parameter int TRANS_FRAMES = 8,
  parameter int FADE_W = 3
) (
  input  logic              CLOCK_25,
  input  logic              reset,
  input  logic [9:0]        h_counter,
  input  logic [9:0]        v_counter,
  input  logic              frame_start,
  maze_room_map_if.slave    mv,
  output logic              wall_px,
  output logic [2:0]        room_x,
  output logic [2:0]        room_y,
  output logic              room_changed,
  output side_t             exit_side,
  output logic              busy,
  output logic [FADE_W-1:0] fade
);
  localparam int N = MAP_W * MAP_H;
  localparam logic [FADE_W-1:0] F_MAX = FADE_W'(TRANS_FRAMES - 1);
  state_t state, state_n;
  logic [FADE_W-1:0] fade_n;
  side_t pend, mv_side;
  logic [3:0] rooms [64];
  logic [5:0] room_idx;
  logic [3:0] mask, px_out, mv_out, nb_ok;
  logic px_hit, mv_hit, move_ok, exit_go, take_exit;
  for (genvar i = 0; i < 64; i++) begin : g_room
    if (i < N) begin : g_used
      assign rooms[i] = MAP_INIT[i*4 +: 4];
    end else begin : g_pad
      assign rooms[i] = 4'd0;
    end
  end
  assign room_idx = 6'(room_y) * 6'(MAP_W) + 6'(room_x);
  assign mask = rooms[room_idx];
  maze_wall_test #(.H_OFF(H_OFF), .V_OFF(V_OFF), .H_ACT(H_ACT), .V_ACT(V_ACT), .WALL(WALL), .BOX(1)) u_px (
    .x({1'b0, h_counter}), .y({1'b0, v_counter}), .mask(mask), .hit(px_hit), .out(px_out)
  );
  maze_wall_test #(.H_OFF(H_OFF), .V_OFF(V_OFF), .H_ACT(H_ACT), .V_ACT(V_ACT), .WALL(WALL), .BOX(PLAYER)) u_mv (
    .x({1'b0, mv.next_x}), .y({1'b0, mv.next_y}), .mask(mask), .hit(mv_hit), .out(mv_out)
  );
  // neighbour existence indexed by side_t: {W, S, E, N}
  assign nb_ok = {room_x != 3'd0, room_y != 3'(MAP_H - 1), room_x != 3'(MAP_W - 1), room_y != 3'd0};
  assign mv_side = mv_out[BIT_N] ? SIDE_N : mv_out[BIT_E] ? SIDE_E : mv_out[BIT_S] ? SIDE_S : SIDE_W;
  assign move_ok = !mv_hit && mv_out == 4'd0;
  assign exit_go = !mv_hit && $onehot(mv_out) && mask[side_bit(mv_side)] && nb_ok[mv_side];
  assign take_exit = mv.next_valid && state == ST_IDLE && exit_go;
  assign busy = state != ST_IDLE;
  assign room_changed = state == ST_SWAP;
  always_comb begin
    state_n = state;
    fade_n = fade;
    case (state)
      ST_IDLE: state_n = take_exit ? ST_FADE_OUT : ST_IDLE;
      ST_FADE_OUT: if (frame_start) begin
        state_n = fade == F_MAX ? ST_SWAP : ST_FADE_OUT;
        fade_n = fade == F_MAX ? fade : fade + 1'b1;
      end
      ST_SWAP: state_n = ST_FADE_IN;
      default: if (frame_start) begin
        state_n = fade == '0 ? ST_IDLE : ST_FADE_IN;
        fade_n = fade == '0 ? fade : fade - 1'b1;
      end
    endcase
  end
  always_ff @(posedge CLOCK_25 or negedge reset)
    if (!reset) begin
      state <= ST_IDLE;
      fade <= '0;
      pend <= SIDE_N;
      exit_side <= SIDE_N;
      room_x <= 3'(START_X);
      room_y <= 3'(START_Y);
      wall_px <= 1'b0;
      mv.next_ok <= 1'b0;
      mv.next_blocked <= 1'b0;
    end else begin
      state <= state_n;
      fade <= fade_n;
      wall_px <= px_hit & ~|px_out;
      mv.next_ok <= mv.next_valid && state == ST_IDLE && move_ok;
      mv.next_blocked <= mv.next_valid && (state != ST_IDLE || !(move_ok || exit_go));
      if (take_exit) pend <= mv_side;
      // the new room becomes visible in the same cycle room_changed is high
      if (state_n == ST_SWAP) begin
        exit_side <= pend;
        room_x <= pend == SIDE_E ? room_x + 3'd1 : pend == SIDE_W ? room_x - 3'd1 : room_x;
        room_y <= pend == SIDE_S ? room_y + 3'd1 : pend == SIDE_N ? room_y - 3'd1 : room_y;
      end
    end
endmodule

// File: tb/tb_maze_room_map.sv
// tb_maze_room_map: randomized and directed checks of maze_room_map against a pixel-level reference model
module tb_maze_room_map;
  import maze_pkg::*;
  localparam int MAP_W = 3, MAP_H = 3, START_X = 1, START_Y = 2;
  localparam int H_OFF = 96, V_OFF = 2, H_ACT = 640, V_ACT = 480, WALL = 100, PLAYER = 16, T = 8;
  localparam logic [35:0] MAP = {4'h6, 4'h3, 4'hD, 4'h0, ROOM_CROSS, ROOM_VERT, ROOM_CROSS, ROOM_HORZ, ROOM_VERT};
  logic CLOCK_25 = 1'b0, reset = 1'b0, frame_start = 1'b0;
  logic [9:0] h_counter = '0, v_counter = '0;
  logic wall_px, room_changed, busy;
  logic [2:0] room_x, room_y, fade;
  logic [1:0] exit_side;
  int checks = 0, errors = 0, rx = START_X, ry = START_Y;
  maze_room_map_if mv();
  maze_room_map #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .MAP_INIT(MAP), .START_X(START_X), .START_Y(START_Y),
    .H_OFF(H_OFF), .V_OFF(V_OFF), .H_ACT(H_ACT), .V_ACT(V_ACT), .WALL(WALL), .PLAYER(PLAYER),
    .TRANS_FRAMES(T), .FADE_W(3)
  ) dut (
    .CLOCK_25(CLOCK_25), .reset(reset), .h_counter(h_counter), .v_counter(v_counter),
    .frame_start(frame_start), .mv(mv), .wall_px(wall_px), .room_x(room_x), .room_y(room_y),
    .room_changed(room_changed), .exit_side(exit_side), .busy(busy), .fade(fade)
  );
  always #20 CLOCK_25 = ~CLOCK_25;
  function automatic logic [3:0] room_mask(int x, int y);
    return MAP[(y*MAP_W + x)*4 +: 4];
  endfunction
  // a pixel is wall if active and in a corner or in the band of a closed side
  function automatic bit px_wall(int h, int v, logic [3:0] m);
    int lx = h - H_OFF, ly = v - V_OFF;
    bit n, s, w, e;
    if (lx < 0 || ly < 0 || lx >= H_ACT || ly >= V_ACT) return 1'b0;
    n = ly < WALL; s = ly >= V_ACT - WALL; w = lx < WALL; e = lx >= H_ACT - WALL;
    if ((n || s) && (w || e)) return 1'b1;
    return (n && !m[3]) || (e && !m[2]) || (s && !m[1]) || (w && !m[0]);
  endfunction
  // 0 = accepted move, 1 = blocked, 2+side = exit accepted through side (0=N,1=E,2=S,3=W)
  function automatic int judge(int nx, int ny, logic [3:0] m, int cx, int cy);
    bit hit = 1'b0;
    bit o [4];
    int cnt = 0, side = 0, tx, ty;
    for (int dy = 0; dy < PLAYER; dy++)
      for (int dx = 0; dx < PLAYER; dx++)
        if (px_wall(nx + dx, ny + dy, m)) hit = 1'b1;
    o[0] = ny < V_OFF;
    o[1] = nx + PLAYER > H_OFF + H_ACT;
    o[2] = ny + PLAYER > V_OFF + V_ACT;
    o[3] = nx < H_OFF;
    if (hit) return 1;
    for (int k = 3; k >= 0; k--) if (o[k]) begin cnt++; side = k; end
    if (cnt == 0) return 0;
    if (cnt > 1 || !m[3 - side]) return 1;
    tx = cx + (side == 1 ? 1 : 0) - (side == 3 ? 1 : 0);
    ty = cy + (side == 2 ? 1 : 0) - (side == 0 ? 1 : 0);
    if (tx < 0 || ty < 0 || tx >= MAP_W || ty >= MAP_H) return 1;
    return 2 + side;
  endfunction
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_25);
    checks++;
    if ({wall_px, mv.next_ok, mv.next_blocked, room_changed, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {wall_px, mv.next_ok, mv.next_blocked, room_changed, busy});
    end
    checks++;
    if (room_x !== 3'(START_X) || room_y !== 3'(START_Y)) begin
      errors++; $display("FAIL reset_room got (%0d,%0d) want (%0d,%0d)", room_x, room_y, START_X, START_Y);
    end
    checks++;
    if (fade !== 3'd0 || exit_side !== 2'd0) begin
      errors++; $display("FAIL reset_fade_side got fade=%0d side=%0d want 0 0", fade, exit_side);
    end
    reset = 1'b1;
    @(negedge CLOCK_25);
    checks++;
    if (busy !== 1'b0 || fade !== 3'd0) begin
      errors++; $display("FAIL after_reset got busy=%b fade=%0d want 0 0", busy, fade);
    end
  endtask
  task automatic test_wall_px(int n);
    int hs [10] = '{100, 400, 400, 96, 95, 735, 736, 400, 400, 400};
    int vs [10] = '{10, 10, 250, 2, 2, 250, 250, 481, 101, 102};
    logic [3:0] m = room_mask(rx, ry);
    int ph = hs[0], pv = vs[0];
    @(negedge CLOCK_25);
    h_counter = 10'(ph); v_counter = 10'(pv);
    for (int i = 1; i <= n; i++) begin
      @(negedge CLOCK_25);
      checks++;
      if (wall_px !== px_wall(ph, pv, m)) begin
        errors++; $display("FAIL wall_px h=%0d v=%0d got %b want %b", ph, pv, wall_px, px_wall(ph, pv, m));
      end
      ph = i < 10 ? hs[i] : int'($urandom_range(0, 799));
      pv = i < 10 ? vs[i] : int'($urandom_range(0, 524));
      h_counter = 10'(ph); v_counter = 10'(pv);
    end
  endtask
  task automatic test_moves(int n);
    logic [3:0] m = room_mask(rx, ry);
    int nx, ny, code;
    for (int i = 0; i < n; i++) begin
      do begin
        nx = $urandom_range(0, 760); ny = $urandom_range(0, 510);
        code = judge(nx, ny, m, rx, ry);
      end while (code >= 2);
      @(negedge CLOCK_25);
      mv.next_x = 10'(nx); mv.next_y = 10'(ny); mv.next_valid = 1'b1;
      @(negedge CLOCK_25);
      mv.next_valid = 1'b0;
      checks++;
      if (mv.next_ok !== (code == 0) || mv.next_blocked !== (code == 1) || busy !== 1'b0) begin
        errors++; $display("FAIL move (%0d,%0d) got ok=%b blk=%b busy=%b want ok=%b blk=%b busy=0",
          nx, ny, mv.next_ok, mv.next_blocked, busy, code == 0, code == 1);
      end
    end
  endtask
  task automatic test_back_to_back(int n);
    logic [3:0] m = room_mask(rx, ry);
    int nx, ny, code, prev;
    prev = -1;
    for (int i = 0; i <= n; i++) begin
      do begin
        nx = $urandom_range(0, 760); ny = $urandom_range(0, 510);
        code = judge(nx, ny, m, rx, ry);
      end while (code >= 2);
      @(negedge CLOCK_25);
      if (prev >= 0) begin
        checks++;
        if (mv.next_ok !== (prev == 0) || mv.next_blocked !== (prev == 1)) begin
          errors++; $display("FAIL b2b #%0d got ok=%b blk=%b want ok=%b blk=%b", i, mv.next_ok, mv.next_blocked, prev == 0, prev == 1);
        end
      end
      mv.next_x = 10'(nx); mv.next_y = 10'(ny); mv.next_valid = i < n;
      prev = i < n ? code : -1;
    end
    @(negedge CLOCK_25);
    checks++;
    if (mv.next_ok !== 1'b0 || mv.next_blocked !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got ok=%b blk=%b want 0 0", mv.next_ok, mv.next_blocked);
    end
  endtask
  task automatic test_no_neighbour();
    @(negedge CLOCK_25);
    mv.next_x = 10'd90; mv.next_y = 10'd200; mv.next_valid = 1'b1;
    @(negedge CLOCK_25);
    mv.next_valid = 1'b0;
    checks++;
    if (mv.next_blocked !== 1'b1 || mv.next_ok !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL no_neighbour got blk=%b ok=%b busy=%b want 1 0 0", mv.next_blocked, mv.next_ok, busy);
    end
    @(negedge CLOCK_25);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL no_neighbour_busy got %b want 0", busy);
    end
  endtask
  task automatic test_corridor();
    @(negedge CLOCK_25);
    mv.next_x = 10'd300; mv.next_y = 10'd200; mv.next_valid = 1'b1;
    @(negedge CLOCK_25);
    mv.next_x = 10'd150;
    checks++;
    if (mv.next_ok !== 1'b1 || mv.next_blocked !== 1'b0) begin
      errors++; $display("FAIL corridor_ok got ok=%b blk=%b want 1 0", mv.next_ok, mv.next_blocked);
    end
    @(negedge CLOCK_25);
    mv.next_valid = 1'b0;
    checks++;
    if (mv.next_ok !== 1'b0 || mv.next_blocked !== 1'b1) begin
      errors++; $display("FAIL corridor_blk got ok=%b blk=%b want 0 1", mv.next_ok, mv.next_blocked);
    end
  endtask
  task automatic request_exit(int nx, int ny, output int side);
    side = judge(nx, ny, room_mask(rx, ry), rx, ry) - 2;
    @(negedge CLOCK_25);
    mv.next_x = 10'(nx); mv.next_y = 10'(ny); mv.next_valid = 1'b1;
    @(negedge CLOCK_25);
    mv.next_valid = 1'b0;
    checks++;
    if (mv.next_ok !== 1'b0 || mv.next_blocked !== 1'b0 || busy !== 1'b1 || fade !== 3'd0) begin
      errors++; $display("FAIL exit_accept (%0d,%0d) got ok=%b blk=%b busy=%b fade=%0d want 0 0 1 0",
        nx, ny, mv.next_ok, mv.next_blocked, busy, fade);
    end
  endtask
  task automatic test_transition(int nx, int ny);
    int side, tx, ty;
    request_exit(nx, ny, side);
    tx = rx + (side == 1 ? 1 : 0) - (side == 3 ? 1 : 0);
    ty = ry + (side == 2 ? 1 : 0) - (side == 0 ? 1 : 0);
    for (int k = 1; k <= T; k++) begin
      @(negedge CLOCK_25);
      frame_start = 1'b1;
      mv.next_x = 10'd300; mv.next_y = 10'd200; mv.next_valid = k == 3;
      @(negedge CLOCK_25);
      frame_start = 1'b0; mv.next_valid = 1'b0;
      if (k == 3) begin
        checks++;
        if (mv.next_blocked !== 1'b1 || mv.next_ok !== 1'b0) begin
          errors++; $display("FAIL busy_request got blk=%b ok=%b want 1 0", mv.next_blocked, mv.next_ok);
        end
      end
      checks++;
      if (k < T && (fade !== 3'(k) || busy !== 1'b1 || room_changed !== 1'b0)) begin
        errors++; $display("FAIL fade_out #%0d got fade=%0d busy=%b chg=%b want %0d 1 0", k, fade, busy, room_changed, k);
      end else if (k == T && (room_changed !== 1'b1 || room_x !== 3'(tx) || room_y !== 3'(ty) || exit_side !== 2'(side) || fade !== 3'(T-1))) begin
        errors++; $display("FAIL swap got chg=%b room=(%0d,%0d) side=%0d fade=%0d want 1 (%0d,%0d) %0d %0d",
          room_changed, room_x, room_y, exit_side, fade, tx, ty, side, T-1);
      end
    end
    frame_start = 1'b1;
    @(negedge CLOCK_25);
    frame_start = 1'b0;
    checks++;
    if (room_changed !== 1'b0 || fade !== 3'(T-1) || busy !== 1'b1) begin
      errors++; $display("FAIL swap_end got chg=%b fade=%0d busy=%b want 0 %0d 1", room_changed, fade, busy, T-1);
    end
    for (int k = 1; k <= T; k++) begin
      @(negedge CLOCK_25);
      frame_start = 1'b1;
      @(negedge CLOCK_25);
      frame_start = 1'b0;
      checks++;
      if (k < T && (fade !== 3'(T-1-k) || busy !== 1'b1)) begin
        errors++; $display("FAIL fade_in #%0d got fade=%0d busy=%b want %0d 1", k, fade, busy, T-1-k);
      end else if (k == T && (fade !== 3'd0 || busy !== 1'b0)) begin
        errors++; $display("FAIL fade_in_end got fade=%0d busy=%b want 0 0", fade, busy);
      end
    end
    rx = tx; ry = ty;
  endtask
  task automatic test_reset_mid(int nx, int ny);
    int side;
    request_exit(nx, ny, side);
    repeat (4) begin
      @(negedge CLOCK_25);
      frame_start = 1'b1;
      @(negedge CLOCK_25);
      frame_start = 1'b0;
    end
    checks++;
    if (fade !== 3'd4 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_abort got fade=%0d busy=%b want 4 1", fade, busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (room_x !== 3'(START_X) || room_y !== 3'(START_Y) || fade !== 3'd0 || busy !== 1'b0 || room_changed !== 1'b0) begin
      errors++; $display("FAIL abort got room=(%0d,%0d) fade=%0d busy=%b chg=%b want (%0d,%0d) 0 0 0",
        room_x, room_y, fade, busy, room_changed, START_X, START_Y);
    end
    @(negedge CLOCK_25);
    reset = 1'b1;
    rx = START_X; ry = START_Y;
    @(negedge CLOCK_25);
    frame_start = 1'b1;
    @(negedge CLOCK_25);
    frame_start = 1'b0;
    checks++;
    if (fade !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_frame got fade=%0d busy=%b want 0 0", fade, busy);
    end
  endtask
  initial begin
    mv.next_x = '0; mv.next_y = '0; mv.next_valid = 1'b0;
    test_reset();
    test_wall_px(60);
    test_moves(30);
    test_back_to_back(20);
    test_transition(90, 200);
    test_no_neighbour();
    test_wall_px(30);
    test_moves(20);
    test_transition(300, 0);
    test_corridor();
    test_moves(20);
    test_reset_mid(300, 0);
    test_wall_px(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
